// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahb_arb_pkg
// Purpose : Shared AHB-Lite encodings and the address-phase bundle used by
//           the two-master arbiter (ahb_lite_arb2) and its pending stage.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ahb_arb_pkg;

  // Width of the stored address inside ahb_aphase_t. The top level casts
  // its AW-wide ports to and from this width.
  localparam int AHB_AW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase attributes of one transfer. HTRANS is not stored: every
  // transfer leaves the arbiter as NONSEQ.
  typedef struct packed {
    logic [AHB_AW-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
  } ahb_aphase_t;

endpackage : ahb_arb_pkg
`default_nettype wire

// File: rtl/ahb_arb_pend.sv
`default_nettype none
// ============================================================================
// Module  : ahb_arb_pend
// Purpose : One-entry pending stage for one master. Holds a request the
//           master handed off (it saw hready=1) that lost arbitration or met
//           a stalled slave, and presents either that entry or the live bus
//           as this master's candidate.
// Ports   : clk, rst     - clock, async active-high reset
//           live_req     - master presents a request that is sampled now
//           live         - master's live address phase
//           issue        - this master's candidate goes to the slave now
//           pend_v       - pending entry is occupied
//           cand_v/cand  - candidate valid / candidate address phase
// Revision: 1.0 - initial release
// ============================================================================
module ahb_arb_pend
  import ahb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        live_req,
  input  ahb_aphase_t live,
  input  logic        issue,
  output logic        pend_v,
  output logic        cand_v,
  output ahb_aphase_t cand
);

  logic        r_pend_v;
  ahb_aphase_t r_pend;

  // live_req is gated by this master's hready, which is low while the entry
  // is occupied, so a live sample can never collide with a held one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v <= 1'b0;
      r_pend   <= '0;
    end else if (r_pend_v) begin
      if (issue) r_pend_v <= 1'b0;
    end else if (live_req && !issue) begin
      r_pend_v <= 1'b1;
      r_pend   <= live;
    end
  end

  assign pend_v = r_pend_v;
  assign cand_v = r_pend_v | live_req;
  assign cand   = r_pend_v ? r_pend : live;

endmodule : ahb_arb_pend
`default_nettype wire

// File: rtl/ahb_lite_arb2.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_arb2
// Purpose : Two-master AHB-Lite arbiter onto one AHB-Lite slave. Single
//           transfers, round-robin on ties, zero added latency when
//           uncontended; a losing master is held in a one-entry pending stage
//           and stalled through its hready.
// Ports   : clk, rst                  - clock, async active-high reset
//           m0_* / m1_*               - master address/data/response ports
//           s_*                       - slave-side AHB-Lite port
//           dph_owner                 - master owning the slave data phase
// Revision: 1.0 - initial release
// ============================================================================
module ahb_lite_arb2
  import ahb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [3:0]    m0_hprot,
  input  logic [DW-1:0] m0_hwdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  output logic [DW-1:0] m0_hrdata,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [3:0]    m1_hprot,
  input  logic [DW-1:0] m1_hwdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [DW-1:0] m1_hrdata,
  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [3:0]    s_hprot,
  output logic [DW-1:0] s_hwdata,
  input  logic          s_hready,
  input  logic          s_hresp,
  input  logic [DW-1:0] s_hrdata,
  output logic          dph_owner
);

  logic        r_dph_v;
  logic        r_dph_owner;
  logic        r_rr_last;

  logic        w_live_req0, w_live_req1;
  logic        w_pend_v0, w_pend_v1;
  logic        w_cand_v0, w_cand_v1;
  ahb_aphase_t w_live0, w_live1, w_cand0, w_cand1, w_sel;
  logic        w_issue, w_winner;

  // HTRANS[1] is set for NONSEQ and SEQ, so SEQ is taken as a request too.
  assign w_live_req0 = m0_htrans[1] & m0_hready;
  assign w_live_req1 = m1_htrans[1] & m1_hready;

  // Addresses are carried at the package width; AW is expected to be <= it.
  assign w_live0 = '{haddr: AHB_AW'(m0_haddr), hwrite: m0_hwrite,
                     hsize: m0_hsize, hprot: m0_hprot};
  assign w_live1 = '{haddr: AHB_AW'(m1_haddr), hwrite: m1_hwrite,
                     hsize: m1_hsize, hprot: m1_hprot};

  // rst gates the issue term so the slave sees IDLE for the whole reset,
  // even if a master keeps presenting a request.
  assign w_issue  = ~rst & s_hready & (w_cand_v0 | w_cand_v1);
  assign w_winner = (w_cand_v0 & w_cand_v1) ? ~r_rr_last : w_cand_v1;

  ahb_arb_pend u_pend0 (
    .clk      (clk),
    .rst      (rst),
    .live_req (w_live_req0),
    .live     (w_live0),
    .issue    (w_issue & ~w_winner),
    .pend_v   (w_pend_v0),
    .cand_v   (w_cand_v0),
    .cand     (w_cand0)
  );

  ahb_arb_pend u_pend1 (
    .clk      (clk),
    .rst      (rst),
    .live_req (w_live_req1),
    .live     (w_live1),
    .issue    (w_issue & w_winner),
    .pend_v   (w_pend_v1),
    .cand_v   (w_cand_v1),
    .cand     (w_cand1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dph_v     <= 1'b0;
      r_dph_owner <= 1'b0;
      r_rr_last   <= 1'b1;   // M0 wins the first tie
    end else if (s_hready) begin
      if (w_issue) begin
        r_dph_v     <= 1'b1;
        r_dph_owner <= w_winner;
        r_rr_last   <= w_winner;
      end else begin
        r_dph_v     <= 1'b0;
      end
    end
  end

  assign w_sel    = w_winner ? w_cand1 : w_cand0;
  assign s_htrans = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr  = AW'(w_sel.haddr);
  assign s_hwrite = w_sel.hwrite;
  assign s_hsize  = w_sel.hsize;
  assign s_hprot  = w_sel.hprot;
  assign s_hwdata = r_dph_owner ? m1_hwdata : m0_hwdata;

  // The data-phase owner follows the slave; a master with a held entry is
  // stalled; everyone else may present a new request.
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    m0_hresp  = HRESP_OKAY;
    m1_hresp  = HRESP_OKAY;
    if (r_dph_v && !r_dph_owner) begin
      m0_hready = s_hready;
      m0_hresp  = s_hresp;
    end else if (w_pend_v0) begin
      m0_hready = 1'b0;
    end
    if (r_dph_v && r_dph_owner) begin
      m1_hready = s_hready;
      m1_hresp  = s_hresp;
    end else if (w_pend_v1) begin
      m1_hready = 1'b0;
    end
  end

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign dph_owner = r_dph_owner;

endmodule : ahb_lite_arb2
`default_nettype wire
